mdiv_issue_latch: RTL and testbench



---
 rtl/mdiv_pkg.sv | 11 +
 rtl/mdiv_timeout_ctr.sv | 20 ++
 rtl/mdiv_issue_latch.sv | 97 +++++++++
 tb/tb_mdiv_issue_latch.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mdiv_pkg.sv
// mdiv_pkg: shared state encoding and default widths for the mult/div issue latch
package mdiv_pkg;
  localparam int MDIV_DATA_W = 32;
  localparam int MDIV_IR_W = 32;
  typedef enum logic [1:0] {
    MDIV_IDLE    = 2'b00,
    MDIV_BUSY    = 2'b01,
    MDIV_DONE    = 2'b10,
    MDIV_ILLEGAL = 2'b11
  } mdiv_state_e;
endpackage

// File: rtl/mdiv_timeout_ctr.sv
// mdiv_timeout_ctr: counts BUSY cycles and flags expiry on the TIMEOUT_CYCLES-th one
module mdiv_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic busy_i,
  output logic expired_o
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_d = clear_i ? '0 : busy_i ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  // the counter is cleared as BUSY is entered, so it reads N-1 in the Nth BUSY cycle
  assign expired_o = busy_i & (cnt_q == W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/mdiv_issue_latch.sv
// mdiv_issue_latch: operand/IR holding stage and result latch in front of the iterative mult/div unit.
// Optional BUSY timeout abort is enabled by defining MDIV_TIMEOUT_EN.
module mdiv_issue_latch import mdiv_pkg::*; #(
  parameter int DATA_W = MDIV_DATA_W,
  parameter int IR_W = MDIV_IR_W,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              issue,
  input  logic              is_div,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [IR_W-1:0]   in_ir,
  input  logic              flush,
  input  logic              unit_ready,
  input  logic [DATA_W-1:0] unit_result,
  input  logic              unit_exc,
  input  logic              wb_ack,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [IR_W-1:0]   out_ir,
  output logic              out_is_div,
  output logic              unit_start,
  output logic              busy,
  output logic              stall,
  output logic              result_valid,
  output logic [DATA_W-1:0] result,
  output logic              exc
);
  mdiv_state_e       state_q, state_d;
  logic [DATA_W-1:0] a_q, b_q, res_q;
  logic [IR_W-1:0]   ir_q;
  logic              div_q, start_q, exc_q;
  logic              in_idle, in_busy, in_done, accept, capture, timeout;
  assign in_idle = state_q == MDIV_IDLE;
  assign in_busy = state_q == MDIV_BUSY;
  assign in_done = state_q == MDIV_DONE;
  assign accept  = issue & ~flush & (in_idle | (in_done & wb_ack));
  assign capture = in_busy & ~flush & (unit_ready | timeout);
`ifdef MDIV_TIMEOUT_EN
  mdiv_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear_i   (accept),
    .busy_i    (in_busy),
    .expired_o (timeout)
  );
`else
  // never true: without the feature BUSY waits for unit_ready indefinitely
  assign timeout = TIMEOUT_CYCLES < 0;
`endif
  always_comb begin
    state_d = state_q;
    if (flush) state_d = MDIV_IDLE;
    else if (accept) state_d = MDIV_BUSY;
    else if (capture) state_d = MDIV_DONE;
    else if ((in_done & wb_ack) | (state_q == MDIV_ILLEGAL)) state_d = MDIV_IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= MDIV_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ir_q    <= '0;
      div_q   <= 1'b0;
      start_q <= 1'b0;
      res_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= accept;
      if (accept) begin
        a_q   <= in_a;
        b_q   <= in_b;
        ir_q  <= in_ir;
        div_q <= is_div;
      end
      if (capture) begin
        res_q <= unit_ready ? unit_result : '0;
        exc_q <= unit_ready ? unit_exc : 1'b1;
      end else if (flush | (in_done & wb_ack)) begin
        exc_q <= 1'b0;
      end
    end
  end
  assign out_a        = a_q;
  assign out_b        = b_q;
  assign out_ir       = ir_q;
  assign out_is_div   = div_q;
  assign unit_start   = start_q;
  assign busy         = ~in_idle;
  assign stall        = issue & busy & ~(in_done & wb_ack) & ~flush;
  assign result_valid = in_done;
  assign result       = res_q;
  assign exc          = exc_q;
endmodule

// File: tb/tb_mdiv_issue_latch.sv
// tb_mdiv_issue_latch: directed self-checking bench for mdiv_issue_latch
module tb_mdiv_issue_latch;
  localparam int DW = 32;
  localparam int IW = 32;
  logic clk = 1'b0, reset_n = 1'b0, issue = 1'b0, is_div = 1'b0, flush = 1'b0;
  logic unit_ready = 1'b0, unit_exc = 1'b0, wb_ack = 1'b0;
  logic [DW-1:0] in_a = '0, in_b = '0, unit_result = '0;
  logic [IW-1:0] in_ir = '0;
  logic [DW-1:0] out_a, out_b, result;
  logic [IW-1:0] out_ir;
  logic out_is_div, unit_start, busy, stall, result_valid, exc;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  mdiv_issue_latch #(.DATA_W(DW), .IR_W(IW), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .issue(issue), .is_div(is_div),
    .in_a(in_a), .in_b(in_b), .in_ir(in_ir), .flush(flush),
    .unit_ready(unit_ready), .unit_result(unit_result), .unit_exc(unit_exc), .wb_ack(wb_ack),
    .out_a(out_a), .out_b(out_b), .out_ir(out_ir), .out_is_div(out_is_div),
    .unit_start(unit_start), .busy(busy), .stall(stall), .result_valid(result_valid),
    .result(result), .exc(exc)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet;
    issue = 1'b0; flush = 1'b0; unit_ready = 1'b0; unit_exc = 1'b0; wb_ack = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    quiet();
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    checks++; if ({out_a, out_b, out_ir, out_is_div, unit_start, busy, stall, result_valid, result, exc} !== '0) begin errors++; $display("FAIL reset_state: a=%h b=%h ir=%h div=%b start=%b busy=%b stall=%b rv=%b res=%h exc=%b, all must be 0", out_a, out_b, out_ir, out_is_div, unit_start, busy, stall, result_valid, result, exc); end
  endtask

  task automatic test_basic;
    int starts;
    in_a = 7; in_b = 6; is_div = 1'b0; in_ir = 32'h0000_0C10; issue = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL basic_idle_stall: got %b want 0", stall); end
    tick();
    issue = 1'b0; in_a = 32'hFFFF; in_b = 32'hEEEE;
    #1;
    checks++; if ({out_a, out_b, out_ir} !== {32'd7, 32'd6, 32'h0000_0C10}) begin errors++; $display("FAIL basic_capture: a=%0d b=%0d ir=%h want 7 6 00000c10", out_a, out_b, out_ir); end
    checks++; if ({unit_start, busy, out_is_div} !== 3'b110) begin errors++; $display("FAIL basic_start: start/busy/div=%b want 110", {unit_start, busy, out_is_div}); end
    starts = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      starts += int'(unit_start);
    end
    unit_ready = 1'b1; unit_result = 42;
    tick();
    unit_ready = 1'b0; unit_result = 32'h999;
    #1;
    checks++; if (starts !== 1) begin errors++; $display("FAIL basic_start_count: got %0d want 1", starts); end
    checks++; if ({result_valid, exc} !== 2'b10 || result !== 32'd42) begin errors++; $display("FAIL basic_result: rv=%b exc=%b res=%0d want 1 0 42", result_valid, exc, result); end
    tick();
    checks++; if (result_valid !== 1'b1 || result !== 32'd42) begin errors++; $display("FAIL basic_hold: rv=%b res=%0d want 1 42", result_valid, result); end
    wb_ack = 1'b1;
    tick();
    quiet();
    #1;
    checks++; if ({result_valid, busy} !== 2'b00) begin errors++; $display("FAIL basic_ack: rv/busy=%b want 00", {result_valid, busy}); end
  endtask

  task automatic test_stall;
    int starts;
    in_a = 7; in_b = 6; issue = 1'b1;
    tick();
    in_a = 1; wb_ack = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_flag: got %b want 1", stall); end
    starts = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      starts += int'(unit_start);
    end
    checks++; if (out_a !== 32'd7 || starts !== 0) begin errors++; $display("FAIL stall_hold: a=%0d starts=%0d want 7 0", out_a, starts); end
    checks++; if ({busy, result_valid} !== 2'b10) begin errors++; $display("FAIL stall_ack_ignored: busy/rv=%b want 10", {busy, result_valid}); end
    quiet();
    unit_ready = 1'b1; unit_result = 100; unit_exc = 1'b1;
    tick();
    quiet();
    #1;
    checks++; if ({result_valid, exc} !== 2'b11 || result !== 32'd100) begin errors++; $display("FAIL stall_result: rv=%b exc=%b res=%0d want 1 1 100", result_valid, exc, result); end
    unit_ready = 1'b1; unit_result = 32'h5;
    tick();
    quiet();
    #1;
    checks++; if (result !== 32'd100 || result_valid !== 1'b1) begin errors++; $display("FAIL done_ready_ignored: res=%0d rv=%b want 100 1", result, result_valid); end
  endtask

  task automatic test_back_to_back;
    wb_ack = 1'b1; issue = 1'b1; in_a = 9; in_b = 3; is_div = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall: got %b want 0", stall); end
    tick();
    quiet();
    #1;
    checks++; if (out_a !== 32'd9 || out_is_div !== 1'b1) begin errors++; $display("FAIL b2b_capture: a=%0d div=%b want 9 1", out_a, out_is_div); end
    checks++; if ({busy, result_valid, unit_start} !== 3'b101) begin errors++; $display("FAIL b2b_state: busy/rv/start=%b want 101", {busy, result_valid, unit_start}); end
    unit_ready = 1'b1; unit_result = 3;
    tick();
    quiet();
    wb_ack = 1'b1;
    tick();
    quiet();
    #1;
    checks++; if (busy !== 1'b0 || result !== 32'd3) begin errors++; $display("FAIL b2b_finish: busy=%b res=%0d want 0 3", busy, result); end
  endtask

  task automatic test_flush;
    in_a = 5; issue = 1'b1;
    tick();
    in_a = 32'h77; flush = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", stall); end
    tick();
    quiet();
    #1;
    checks++; if ({busy, unit_start} !== 2'b00 || out_a !== 32'd5) begin errors++; $display("FAIL flush_busy: busy/start=%b a=%h want 00 5", {busy, unit_start}, out_a); end
    issue = 1'b1; flush = 1'b1; in_a = 32'h88;
    tick();
    quiet();
    #1;
    checks++; if ({busy, unit_start} !== 2'b00 || out_a !== 32'd5) begin errors++; $display("FAIL flush_idle_drop: busy/start=%b a=%h want 00 5", {busy, unit_start}, out_a); end
    unit_ready = 1'b1; unit_result = 32'hDEAD;
    tick();
    quiet();
    #1;
    checks++; if (result_valid !== 1'b0 || result !== 32'd3) begin errors++; $display("FAIL flush_late_ready: rv=%b res=%h want 0 3", result_valid, result); end
    in_a = 5; issue = 1'b1;
    tick();
    quiet();
    unit_ready = 1'b1; unit_result = 32'h55; unit_exc = 1'b1;
    tick();
    quiet();
    flush = 1'b1;
    tick();
    quiet();
    #1;
    checks++; if ({result_valid, exc, busy} !== 3'b000 || result !== 32'h55) begin errors++; $display("FAIL flush_done: rv/exc/busy=%b res=%h want 000 55", {result_valid, exc, busy}, result); end
  endtask

  task automatic test_reset_mid;
    in_a = 32'h11; in_b = 32'h22; in_ir = 32'h33; is_div = 1'b1; issue = 1'b1;
    tick();
    quiet();
    unit_ready = 1'b1; unit_result = 32'h1234; unit_exc = 1'b1;
    tick();
    quiet();
    #1;
    checks++; if (result_valid !== 1'b1 || exc !== 1'b1) begin errors++; $display("FAIL rmid_done: rv=%b exc=%b want 1 1", result_valid, exc); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    checks++; if ({out_a, out_b, out_ir, out_is_div, unit_start, busy, stall, result_valid, result, exc} !== '0) begin errors++; $display("FAIL rmid_zero: a=%h b=%h ir=%h div=%b start=%b busy=%b stall=%b rv=%b res=%h exc=%b, all must be 0", out_a, out_b, out_ir, out_is_div, unit_start, busy, stall, result_valid, result, exc); end
    unit_ready = 1'b1; unit_result = 32'hBEEF;
    tick();
    quiet();
    #1;
    checks++; if (result_valid !== 1'b0 || result !== '0) begin errors++; $display("FAIL rmid_late_ready: rv=%b res=%h want 0 0", result_valid, result); end
  endtask

`ifdef MDIV_TIMEOUT_EN
  task automatic test_timeout;
    in_a = 1; issue = 1'b1;
    tick();
    quiet();
    for (int i = 0; i < 4; i++) begin
      checks++; if ({busy, result_valid} !== 2'b10) begin errors++; $display("FAIL to_busy_%0d: busy/rv=%b want 10", i, {busy, result_valid}); end
      tick();
    end
    checks++; if ({result_valid, exc} !== 2'b11 || result !== '0) begin errors++; $display("FAIL to_expire: rv=%b exc=%b res=%h want 1 1 0", result_valid, exc, result); end
    wb_ack = 1'b1; issue = 1'b1;
    tick();
    quiet();
    for (int i = 0; i < 3; i++) tick();
    unit_ready = 1'b1; unit_result = 32'hAB; unit_exc = 1'b0;
    tick();
    quiet();
    #1;
    checks++; if ({result_valid, exc} !== 2'b10 || result !== 32'hAB) begin errors++; $display("FAIL to_ready_wins: rv=%b exc=%b res=%h want 1 0 ab", result_valid, exc, result); end
    wb_ack = 1'b1;
    tick();
    quiet();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_flush();
    test_reset_mid();
`ifdef MDIV_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
